// File: rtl/pipe_addsub.sv
// ---------------------------------------------------------------------------
// pipe_addsub
//   Pipelined adder/subtractor. The WIDTH-bit operation is split into STAGES
//   equal chunks of CHUNK = WIDTH/STAGES bits. Stage k resolves chunk k using
//   the registered carry of stage k-1, so each carry chain is CHUNK bits long.
//   Operand bits still to be summed and sum bits already produced travel
//   forward with the op. The last stage's registers hold the result and flags.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : a/b/sub valid this cycle
//   in_ready   : operands are accepted this cycle (independent of in_valid)
//   a, b       : WIDTH-bit operands
//   sub        : 0 -> A+B, 1 -> A-B
//   out_valid  : result/flags valid
//   out_ready  : consumer takes the result this cycle
//   result     : {carry-out, sum}; for sub, carry-out=1 means A>=B unsigned
//   ovf        : signed overflow of the WIDTH-bit sum
//   zero       : sum bits are all zero (carry-out ignored)
//   max_val    : constant all-ones, WIDTH bits
// ---------------------------------------------------------------------------
module pipe_addsub #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result,
    output logic             ovf,
    output logic             zero,
    output logic [WIDTH-1:0] max_val
);

    localparam int CHUNK = WIDTH / STAGES;

    typedef logic [WIDTH-1:0] word_t;

    // Per-stage pipeline registers (index k = output of stage k).
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cy_q, cy_d;
    word_t             a_q   [STAGES];
    word_t             a_d   [STAGES];
    word_t             b_q   [STAGES];
    word_t             b_d   [STAGES];
    word_t             sum_q [STAGES];
    word_t             sum_d [STAGES];
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    // Inputs seen by each stage: ports for stage 0, previous registers otherwise.
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    word_t             src_a   [STAGES];
    word_t             src_b   [STAGES];
    word_t             src_sum [STAGES];

    logic              advance;
    logic [CHUNK:0]    chunk;
    logic              msb_cin;

    // Stage inputs, per-chunk addition, global stall and output flag computation.
    always_comb begin
        // A full output that is not being drained freezes the whole pipe.
        advance = ~vld_q[STAGES-1] | out_ready;

        src_v = {STAGES{1'b0}};
        src_c = {STAGES{1'b0}};
        for (int k = 0; k < STAGES; k++) begin
            src_a[k]   = {WIDTH{1'b0}};
            src_b[k]   = {WIDTH{1'b0}};
            src_sum[k] = {WIDTH{1'b0}};
        end

        // Subtraction is A + ~B + 1: invert B once on entry, carry-in = sub.
        src_v[0]   = in_valid;
        src_a[0]   = a;
        if (sub) begin
            src_b[0] = ~b;
        end else begin
            src_b[0] = b;
        end
        src_c[0]   = sub;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k]   = vld_q[k-1];
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_c[k]   = cy_q[k-1];
            src_sum[k] = sum_q[k-1];
        end

        vld_d = vld_q;
        cy_d  = cy_q;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            sum_d[k] = sum_q[k];
        end
        chunk   = {(CHUNK + 1){1'b0}};
        msb_cin = 1'b0;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                chunk = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                      + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, src_c[k]};
                vld_d[k]                  = src_v[k];
                a_d[k]                    = src_a[k];
                b_d[k]                    = src_b[k];
                sum_d[k]                  = src_sum[k];
                sum_d[k][k*CHUNK +: CHUNK] = chunk[CHUNK-1:0];
                cy_d[k]                   = chunk[CHUNK];
            end
            // Carry into the MSB recovered from the MSB full-adder terms.
            msb_cin = src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1]
                    ^ sum_d[STAGES-1][WIDTH-1];
            ovf_d   = msb_cin ^ cy_d[STAGES-1];
            zero_d  = (sum_d[STAGES-1] == {WIDTH{1'b0}});
        end else begin
            msb_cin = 1'b0;
        end
    end

    // Pipeline state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= {STAGES{1'b0}};
            cy_q   <= {STAGES{1'b0}};
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= {WIDTH{1'b0}};
                b_q[k]   <= {WIDTH{1'b0}};
                sum_q[k] <= {WIDTH{1'b0}};
            end
        end else begin
            vld_q  <= vld_d;
            cy_q   <= cy_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign in_ready  = advance;
    assign out_valid = vld_q[STAGES-1];
    assign result    = {cy_q[STAGES-1], sum_q[STAGES-1]};
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign max_val   = {WIDTH{1'b1}};

endmodule

// File: tb/tb_pipe_addsub.sv
// ---------------------------------------------------------------------------
// tb_pipe_addsub
//   Self-checking bench for pipe_addsub. Instance 0 (W=8,S=2) receives the
//   directed scenarios; all five instances (W=8 S=1/2/4/8, W=16 S=4) run a
//   random stream checked through per-instance expected-result queues.
// ---------------------------------------------------------------------------
module tb_pipe_addsub;

    localparam int N    = 5;
    localparam int NOPS = 10000;
    localparam int WID [N] = '{8, 8, 8, 8, 16};

    localparam logic [7:0] B2B_A [4] = '{8'h10, 8'h90, 8'hFF, 8'h00};
    localparam logic [7:0] B2B_B [4] = '{8'h20, 8'h10, 8'hFF, 8'h01};
    localparam logic       B2B_S [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    logic                   clk;
    logic                   rst_n;
    logic [N-1:0]           iv, ir, ov, ordy, sub_v, ovf, zr;
    logic [N-1:0][15:0]     aa, bb, mx;
    logic [N-1:0][16:0]     rs;

    int checks;
    int errors;
    int sent [N];
    int recv [N];

    logic [18:0] q0 [$];
    logic [18:0] q1 [$];
    logic [18:0] q2 [$];
    logic [18:0] q3 [$];
    logic [18:0] q4 [$];

    pipe_addsub #(.WIDTH(8), .STAGES(2)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(aa[0][7:0]), .b(bb[0][7:0]), .sub(sub_v[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .result(rs[0][8:0]), .ovf(ovf[0]), .zero(zr[0]),
        .max_val(mx[0][7:0]));
    pipe_addsub #(.WIDTH(8), .STAGES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(aa[1][7:0]), .b(bb[1][7:0]), .sub(sub_v[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .result(rs[1][8:0]), .ovf(ovf[1]), .zero(zr[1]),
        .max_val(mx[1][7:0]));
    pipe_addsub #(.WIDTH(8), .STAGES(4)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(aa[2][7:0]), .b(bb[2][7:0]), .sub(sub_v[2]), .out_valid(ov[2]),
        .out_ready(ordy[2]), .result(rs[2][8:0]), .ovf(ovf[2]), .zero(zr[2]),
        .max_val(mx[2][7:0]));
    pipe_addsub #(.WIDTH(8), .STAGES(8)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
        .a(aa[3][7:0]), .b(bb[3][7:0]), .sub(sub_v[3]), .out_valid(ov[3]),
        .out_ready(ordy[3]), .result(rs[3][8:0]), .ovf(ovf[3]), .zero(zr[3]),
        .max_val(mx[3][7:0]));
    pipe_addsub #(.WIDTH(16), .STAGES(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .in_ready(ir[4]),
        .a(aa[4]), .b(bb[4]), .sub(sub_v[4]), .out_valid(ov[4]),
        .out_ready(ordy[4]), .result(rs[4]), .ovf(ovf[4]), .zero(zr[4]),
        .max_val(mx[4]));

    assign rs[0][16:9] = 8'h00;
    assign rs[1][16:9] = 8'h00;
    assign rs[2][16:9] = 8'h00;
    assign rs[3][16:9] = 8'h00;
    assign mx[0][15:8] = 8'h00;
    assign mx[1][15:8] = 8'h00;
    assign mx[2][15:8] = 8'h00;
    assign mx[3][15:8] = 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: exact integer arithmetic, returns {zero, ovf, result[16:0]}.
    function automatic logic [18:0] model(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic s);
        longint mask, ua, ub, tot, lim, sa, sbv, ex;
        logic [16:0] r;
        logic c, o;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        if (s) begin
            tot = ua - ub;
            c   = (ua >= ub);
        end else begin
            tot = ua + ub;
            c   = (tot > mask);
        end
        r    = 17'(tot & mask);
        r[w] = c;
        lim  = longint'(1) << (w - 1);
        sa   = (ua >= lim) ? ua - 2 * lim : ua;
        sbv  = (ub >= lim) ? ub - 2 * lim : ub;
        ex   = s ? sa - sbv : sa + sbv;
        o    = (ex >= lim) || (ex < -lim);
        return {((tot & mask) == 0), o, r};
    endfunction

    task automatic sb_push(input int i, input logic [18:0] v);
        case (i)
            0: q0.push_back(v);
            1: q1.push_back(v);
            2: q2.push_back(v);
            3: q3.push_back(v);
            default: q4.push_back(v);
        endcase
    endtask

    task automatic sb_pop(input int i, output logic [18:0] v, output bit ok);
        v  = 19'h0;
        ok = 1'b0;
        case (i)
            0: if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
            2: if (q2.size() > 0) begin v = q2.pop_front(); ok = 1'b1; end
            3: if (q3.size() > 0) begin v = q3.pop_front(); ok = 1'b1; end
            default: if (q4.size() > 0) begin v = q4.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Drives one op into instance 0 and samples out_valid after edges 1 and 2.
    task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic s,
                           output logic v1, output logic v2, output logic [8:0] r,
                           output logic o, output logic z);
        iv[0] = 1'b1; aa[0] = {8'h00, a}; bb[0] = {8'h00, b}; sub_v[0] = s; ordy[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        v1 = ov[0];
        @(posedge clk); #1;
        v2 = ov[0]; r = rs[0][8:0]; o = ovf[0]; z = zr[0];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [15:0] exp_mx;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({ov[i], rs[i], ovf[i], zr[i]} !== 20'h0) begin
                errors++;
                $display("FAIL reset[%0d] got ov=%b res=%h ovf=%b zero=%b required all 0",
                         i, ov[i], rs[i], ovf[i], zr[i]);
            end
            exp_mx = (WID[i] == 16) ? 16'hFFFF : 16'h00FF;
            checks++;
            if (mx[i] !== exp_mx) begin
                errors++;
                $display("FAIL max_val[%0d] got %h required %h", i, mx[i], exp_mx);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_carry();
        logic v1, v2, o, z;
        logic [8:0] r;
        run_one(8'hFF, 8'h01, 1'b0, v1, v2, r, o, z);
        checks++;
        if ({v1, v2} !== 2'b01) begin
            errors++;
            $display("FAIL latency got valid e1/e2=%b%b required 01", v1, v2);
        end
        checks++;
        if ({r, z, o} !== {9'h100, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL ff_plus_1 got res=%h zero=%b ovf=%b required 100 1 0", r, z, o);
        end
    endtask

    task automatic test_overflow();
        logic v1, v2, o, z;
        logic [8:0] r;
        run_one(8'h7F, 8'h01, 1'b0, v1, v2, r, o, z);
        checks++;
        if ({v2, r, o, z} !== {1'b1, 9'h080, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL 7f_plus_1 got v=%b res=%h ovf=%b zero=%b required 1 080 1 0", v2, r, o, z);
        end
        run_one(8'h80, 8'h01, 1'b1, v1, v2, r, o, z);
        checks++;
        if ({v2, r, o, z} !== {1'b1, 9'h17F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL 80_minus_1 got v=%b res=%h ovf=%b zero=%b required 1 17f 1 0", v2, r, o, z);
        end
    endtask

    task automatic test_sub_borrow();
        logic v1, v2, o, z;
        logic [8:0] r;
        run_one(8'h05, 8'h09, 1'b1, v1, v2, r, o, z);
        checks++;
        if ({v2, r, o, z} !== {1'b1, 9'h0FC, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL 5_minus_9 got v=%b res=%h ovf=%b zero=%b required 1 0fc 0 0", v2, r, o, z);
        end
    endtask

    task automatic test_back_to_back();
        int ns, nr, step;
        logic [18:0] e;
        bit ok;
        ns = 0; nr = 0; step = 0;
        while ((nr < 4) && (step < 30)) begin
            ordy[0] = !((step >= 3) && (step <= 5));
            if (ns < 4) begin
                iv[0] = 1'b1; aa[0] = {8'h00, B2B_A[ns]}; bb[0] = {8'h00, B2B_B[ns]};
                sub_v[0] = B2B_S[ns];
            end else begin
                iv[0] = 1'b0;
            end
            @(negedge clk);
            if (!ordy[0]) begin
                checks++;
                if (ir[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready step %0d got %b required 0", step, ir[0]);
                end
                if (ov[0] && (q0.size() > 0)) begin
                    checks++;
                    if ({zr[0], ovf[0], rs[0]} !== q0[0]) begin
                        errors++;
                        $display("FAIL stall_hold step %0d got %h required %h", step,
                                 {zr[0], ovf[0], rs[0]}, q0[0]);
                    end
                end
            end
            if (ov[0] && ordy[0]) begin
                sb_pop(0, e, ok);
                checks++;
                if (!ok || ({zr[0], ovf[0], rs[0]} !== e)) begin
                    errors++;
                    $display("FAIL b2b_out %0d got %h required %h (queued=%0d)", nr,
                             {zr[0], ovf[0], rs[0]}, e, ok);
                end
                nr++;
            end
            if (iv[0] && ir[0]) begin
                sb_push(0, model(8, aa[0], bb[0], sub_v[0]));
                ns++;
            end
            @(posedge clk); #1;
            step++;
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        checks++;
        if ((nr != 4) || (q0.size() != 0)) begin
            errors++;
            $display("FAIL b2b_count got %0d outputs %0d left required 4 0", nr, q0.size());
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (ov[0] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_duplicate got out_valid=%b required 0", ov[0]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_flight();
        logic v1, v2, o, z;
        logic [8:0] r;
        ordy[0] = 1'b0;
        iv[0] = 1'b1; aa[0] = 16'h0011; bb[0] = 16'h0022; sub_v[0] = 1'b0;
        @(posedge clk); #1;
        aa[0] = 16'h0033; bb[0] = 16'h0044;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        checks++;
        if (ov[0] !== 1'b1) begin
            errors++;
            $display("FAIL inflight_setup got out_valid=%b required 1", ov[0]);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if ({ov[0], rs[0], ovf[0], zr[0]} !== 20'h0) begin
            errors++;
            $display("FAIL inflight_reset got ov=%b res=%h ovf=%b zero=%b required all 0",
                     ov[0], rs[0], ovf[0], zr[0]);
        end
        ordy[0] = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            checks++;
            if (ov[0] !== 1'b0) begin
                errors++;
                $display("FAIL stale_output got out_valid=%b required 0", ov[0]);
            end
        end
        run_one(8'h10, 8'h01, 1'b1, v1, v2, r, o, z);
        checks++;
        if ({v1, v2, r, o, z} !== {1'b0, 1'b1, 9'h10F, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_op got v=%b%b res=%h ovf=%b zero=%b required 01 10f 0 0",
                     v1, v2, r, o, z);
        end
    endtask

    task automatic test_random();
        logic [18:0] e;
        bit ok, done;
        int cyc;
        for (int i = 0; i < N; i++) begin
            sent[i] = 0;
            recv[i] = 0;
        end
        cyc = 0;
        done = 1'b0;
        while (!done && (cyc < 60000)) begin
            for (int i = 0; i < N; i++) begin
                iv[i]    = (sent[i] < NOPS) && ($urandom_range(0, 9) < 8);
                aa[i]    = 16'($urandom);
                bb[i]    = 16'($urandom);
                sub_v[i] = 1'($urandom_range(0, 1));
                ordy[i]  = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (ov[i] && ordy[i]) begin
                    sb_pop(i, e, ok);
                    checks++;
                    if (!ok || ({zr[i], ovf[i], rs[i]} !== e)) begin
                        errors++;
                        $display("FAIL rand[%0d] op %0d got %h required %h (queued=%0d)",
                                 i, recv[i], {zr[i], ovf[i], rs[i]}, e, ok);
                    end
                    recv[i]++;
                end
                if (iv[i] && ir[i]) begin
                    sb_push(i, model(WID[i], aa[i], bb[i], sub_v[i]));
                    sent[i]++;
                end
            end
            @(posedge clk); #1;
            cyc++;
            done = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (recv[i] < NOPS) done = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            iv[i] = 1'b0;
            checks++;
            if (recv[i] != NOPS) begin
                errors++;
                $display("FAIL rand_count[%0d] got %0d results required %0d", i, recv[i], NOPS);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        iv     = '0;
        ordy   = '1;
        sub_v  = '0;
        aa     = '0;
        bb     = '0;
        @(posedge clk); #1;
        test_reset();
        test_add_carry();
        test_overflow();
        test_sub_borrow();
        test_back_to_back();
        test_reset_in_flight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
